// File: rtl/i2si_pkg.sv
// ---------------------------------------------------------------------------
// i2si_pkg
// Shared definitions for the i2s-input source control slice.
//   state_e          : sequencer state encoding (DES, WAIT_DES, BIST, WAIT_BIST)
//   BLANK_CYC_DEF    : default mute window after a source switch
//   CNT_W_DEF        : default width of the BIST pair counter
//   TIMEOUT_CYC_DEF  : default WAIT-state cycle limit (timeout build only)
//   is_wait()        : true for either of the two WAIT states
// ---------------------------------------------------------------------------
package i2si_pkg;

  typedef enum logic [1:0] {
    S_DES       = 2'd0,
    S_WAIT_DES  = 2'd1,
    S_BIST      = 2'd2,
    S_WAIT_BIST = 2'd3
  } state_e;

  localparam int BLANK_CYC_DEF   = 2;
  localparam int CNT_W_DEF       = 16;
  localparam int TIMEOUT_CYC_DEF = 1024;

  function automatic logic is_wait(input state_e s);
    return (s == S_WAIT_DES) || (s == S_WAIT_BIST);
  endfunction

endpackage

// File: rtl/i2si_pair_track.sv
// ---------------------------------------------------------------------------
// i2si_pair_track
// Tracks L/R word parity of the currently selected stream, flags stereo-pair
// boundaries and owns the post-switch mute window.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   xfc         : word strobe of the active source (already muxed by sel)
//   switch_en   : sel changes at the coming clock edge
//   mute        : registered; high for BLANK_CYC cycles after each switch
//   boundary    : this cycle ends on a stereo-pair boundary
//   pair_done   : this cycle completes an L/R pair (R word accepted)
// ---------------------------------------------------------------------------
import i2si_pkg::*;

module i2si_pair_track #(
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic xfc,
  input  logic switch_en,
  output logic mute,
  output logic boundary,
  output logic pair_done
);

  localparam int BW = 4;

  logic          parity_q, parity_d;
  logic          mute_q, mute_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          word;

  // Words arriving while muted are discarded downstream, so they must not
  // advance the L/R phase either.
  assign word      = xfc & ~mute_q;
  // Even phase with no word, or the R word arriving: the next word is an L.
  assign boundary  = parity_q ? word : ~word;
  assign pair_done = parity_q & word;
  assign mute      = mute_q;

  always_comb begin
    parity_d = parity_q ^ word;
    mute_d   = mute_q;
    blank_d  = blank_q;
    // blank_q counts the mute cycles still to go after the current one.
    if (mute_q) begin
      if (blank_q == '0) begin
        mute_d = 1'b0;
      end else begin
        blank_d = blank_q - BW'(1);
      end
    end
    // A switch restarts the stream on an L word and reopens the window.
    if (switch_en) begin
      parity_d = 1'b0;
      mute_d   = 1'b1;
      blank_d  = BW'(BLANK_CYC - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
      mute_q   <= 1'b0;
      blank_q  <= '0;
    end else begin
      parity_q <= parity_d;
      mute_q   <= mute_d;
      blank_q  <= blank_d;
    end
  end

endmodule

// File: rtl/i2si_src_ctrl.sv
// ---------------------------------------------------------------------------
// i2si_src_ctrl
// Sequencer for the i2s-input source mux (sel 0 = deserializer, 1 = BIST).
// Source changes only on stereo-pair boundaries; each change pulses
// bist_start (when entering BIST) and mutes downstream for BLANK_CYC cycles.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bist_req     : level request for the BIST source
//   bist_done    : one-cycle pulse, BIST pattern finished
//   in_0_xfc     : deserializer word strobe
//   in_1_xfc     : BIST word strobe
//   sel          : registered mux select
//   bist_start   : one-cycle pulse when BIST becomes the active source
//   mute         : downstream discards words while high
//   busy         : high in either WAIT state
//   pair_cnt     : saturating count of completed pairs while in BIST
//   err_timeout  : sticky forced-switch flag
// Build option: define I2SI_SRC_CTRL_TIMEOUT_EN to force the switch after
// TIMEOUT_CYC cycles in a WAIT state; otherwise WAIT states wait forever and
// err_timeout is tied low.
// ---------------------------------------------------------------------------
import i2si_pkg::*;

module i2si_src_ctrl #(
  parameter int BLANK_CYC   = BLANK_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bist_req,
  input  logic             bist_done,
  input  logic             in_0_xfc,
  input  logic             in_1_xfc,
  output logic             sel,
  output logic             bist_start,
  output logic             mute,
  output logic             busy,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             err_timeout
);

  if (BLANK_CYC < 1 || BLANK_CYC > 15) begin : g_bad_blank
    $error("i2si_src_ctrl: BLANK_CYC must be in 1..15");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("i2si_src_ctrl: TIMEOUT_CYC must be at least 1");
  end

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             bist_start_q, bist_start_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
  logic             armed_q, armed_d;
  logic             active_xfc;
  logic             switch_en;
  logic             enter_bist;
  logic             boundary;
  logic             pair_done;
  logic             tmo_hit;

  // The strobe of the unselected source never affects pairing.
  assign active_xfc = sel_q ? in_1_xfc : in_0_xfc;

  i2si_pair_track #(
    .BLANK_CYC (BLANK_CYC)
  ) u_pair_track (
    .clk       (clk),
    .rst_n     (rst_n),
    .xfc       (active_xfc),
    .switch_en (switch_en),
    .mute      (mute),
    .boundary  (boundary),
    .pair_done (pair_done)
  );

`ifdef I2SI_SRC_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // tmo_q counts completed WAIT cycles; the TIMEOUT_CYC-th one forces.
  assign tmo_hit     = is_wait(state_q) && !boundary && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;

  always_comb begin
    tmo_d = (is_wait(state_q) && (state_d == state_q)) ? tmo_q + TMO_W'(1) : '0;
    err_d = err_q;
    if (state_q == S_DES && state_d == S_WAIT_DES) begin
      err_d = 1'b0;
    end else if (tmo_hit && switch_en) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state and registered-output decode. Abort by bist_req dropping in
  // WAIT_DES beats a boundary in the same cycle; bist_done beats a still-high
  // bist_req in BIST.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_DES: begin
        if (bist_req && armed_q) state_d = S_WAIT_DES;
      end
      S_WAIT_DES: begin
        if (!bist_req)                state_d = S_DES;
        else if (boundary || tmo_hit) state_d = S_BIST;
      end
      S_BIST: begin
        if (bist_done || !bist_req) state_d = S_WAIT_BIST;
      end
      S_WAIT_BIST: begin
        if (boundary || tmo_hit) state_d = S_DES;
      end
      default: state_d = S_DES;
    endcase

    sel_d        = (state_d == S_BIST) || (state_d == S_WAIT_BIST);
    busy_d       = is_wait(state_d);
    switch_en    = sel_d ^ sel_q;
    enter_bist   = (state_q == S_WAIT_DES) && (state_d == S_BIST);
    bist_start_d = enter_bist;

    pair_cnt_d = pair_cnt_q;
    if (enter_bist) begin
      pair_cnt_d = '0;
    end else if (state_q == S_BIST && pair_done && pair_cnt_q != {CNT_W{1'b1}}) begin
      pair_cnt_d = pair_cnt_q + CNT_W'(1);
    end

    // A held request must drop before BIST can be entered again.
    armed_d = armed_q;
    if (!bist_req) begin
      armed_d = 1'b1;
    end else if (enter_bist) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_DES;
      sel_q        <= 1'b0;
      bist_start_q <= 1'b0;
      busy_q       <= 1'b0;
      pair_cnt_q   <= '0;
      armed_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      bist_start_q <= bist_start_d;
      busy_q       <= busy_d;
      pair_cnt_q   <= pair_cnt_d;
      armed_q      <= armed_d;
    end
  end

  assign sel        = sel_q;
  assign bist_start = bist_start_q;
  assign busy       = busy_q;
  assign pair_cnt   = pair_cnt_q;

endmodule
